seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
//  Shares the 3-digit 7-segment display between two requesters (0: lock FSM, 1: event counter).
//  Grants ownership by request/grant handshake with round-robin tie-break and bounded hold time.
//  Scans the owner's 12-bit hex value across the digits, with a ghost-blank interval per digit.
//  Forces a blank gap on every ownership change. Owns anodes/cathodes outright.
// PARAMETERS
//  SCAN_PERIOD  65536  cycles per digit slot (digit rotates every SCAN_PERIOD cycles)
//  GHOST_CYCLES 256    leading cycles of each slot with anodes off (GHOST_CYCLES < SCAN_PERIOD)
//  BLANK_CYCLES 1024   display-off cycles in SWITCH between owners (>=1)
//  MAX_HOLD     2**26  cycles an owner may hold while the other requester waits
// PORTS
//  clk       in   1   system clock; single clock domain
//  reset     in   1   asynchronous, active-low reset
//  req0      in   1   requester 0 wants display; level, held while wanted
//  data0     in   12  requester 0 value; [3:0] digit0 (right), [7:4] digit1, [11:8] digit2
//  req1      in   1   requester 1 wants display
//  data1     in   12  requester 1 value, same packing
//  gnt0      out  1   registered; requester 0 owns display
//  gnt1      out  1   registered; requester 1 owns display
//  anodes    out  3   active-low digit enables; 3'b110 digit0, 3'b101 digit1, 3'b011 digit2
//  cathodes  out  8   active-low segments {dp,g,f,e,d,c,b,a}; dp always 1 (off)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, gnt0=gnt1=0, anodes=3'b111, cathodes=8'hFF,
//   scan counter 0, digit index 0, hold/blank counters 0, rr pointer favours requester 0.
//  FSM states: IDLE, OWN0, OWN1, SWITCH. gnt0=1 only in OWN0, gnt1=1 only in OWN1; never both.
//  IDLE: only req0 -> OWN0; only req1 -> OWN1; both -> requester not most recently granted.
//   Latency: req seen at edge N -> gnt high after edge N (visible cycle N+1).
//  OWNx: hold counter increments each cycle, saturates at MAX_HOLD.
//   reqx low -> SWITCH (gnt drops same edge).
//   reqx high, other req high, hold==MAX_HOLD -> SWITCH (preempt).
//   Otherwise stay. Display latch loads datax every cycle; display lags data by 1 cycle.
//  SWITCH: gnts 0, anodes 3'b111, cathodes 8'hFF for exactly BLANK_CYCLES cycles.
//   Then arbitrate as IDLE (direct to OWNx if any req, else IDLE).
//   Preempted owner is most recent, so a waiting requester wins.
//  rr pointer updates on entry to OWNx. hold counter clears on every OWN entry.
//  Scan: free-running counter 0..SCAN_PERIOD-1, wraps. Digit index 0->1->2->0 at each wrap.
//   Counter and index run in all states and are unaffected by ownership change.
//  Anodes in OWNx: all off while scan count < GHOST_CYCLES, else pattern for the current digit.
//   IDLE/SWITCH: 3'b111.
//  Cathodes: registered full hex decode of the selected nibble:
//   0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E.
//   8'hFF whenever anodes==3'b111.
//  Simultaneous: owner drop and other req rising on same edge -> SWITCH first, no direct handoff.
//   req pulses shorter than one cycle are not guaranteed to be seen.
//  Reset mid-operation: outputs go to reset values immediately, no blank sequence.
// TESTING  (SCAN_PERIOD=16, GHOST_CYCLES=2, BLANK_CYCLES=4, MAX_HOLD=32)
//  1 Reset held: any req -> gnt0=gnt1=0, anodes=111, cathodes=FF; release with req0=1 -> gnt0=1 next cycle.
//  2 OWN0, data0=12'h3A7: slots show digit0 F8 on 110, digit1 88 on 101, digit2 B0 on 011.
//    Anodes 111 for first 2 cycles of each 16-cycle slot.
//  3 req0,req1 rise same edge after reset -> gnt0.
//    req0 drops -> exactly 4 blank cycles -> gnt1.
//    Both rise again from IDLE -> gnt0 (round-robin).
//  4 OWN1 with req0 waiting: gnt1 held 32 cycles -> SWITCH 4 cycles -> gnt0.
//    No preempt when req0 low: gnt1 persists 100+ cycles.
//  5 Async reset pulsed mid-SWITCH and mid-OWN0: outputs reset without clk edge; scan index restarts at digit0.
//  6 data1 changes 12'h000->12'hFFF in OWN1: active digit cathodes change C0->8E one cycle later.

Source files
------------

// File: rtl/seg_display_arbiter_if.sv
// Request/grant bundle between the two display requesters and the arbiter.
// The master side raises requests and supplies values; the slave side returns grants.
interface seg_display_arbiter_if;
  logic        req0;
  logic [11:0] data0;
  logic        gnt0;
  logic        req1;
  logic [11:0] data1;
  logic        gnt1;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Shares a 3-digit multiplexed 7-segment display between two requesters with
// round-robin arbitration, bounded hold time and a forced blank gap between owners.
module seg_display_arbiter #(
  parameter int SCAN_PERIOD  = 65536,
  parameter int GHOST_CYCLES = 256,
  parameter int BLANK_CYCLES = 1024,
  parameter int MAX_HOLD     = 2**26
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_display_arbiter_if.slave req_bus,
  output logic [2:0]           anodes,
  output logic [7:0]           cathodes
);

  localparam int SCAN_W  = (SCAN_PERIOD  > 1) ? $clog2(SCAN_PERIOD)  : 1;
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int HOLD_W  = $clog2(MAX_HOLD + 1);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_PERIOD - 1);
  localparam logic [SCAN_W-1:0]  GHOST_END  = SCAN_W'(GHOST_CYCLES);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MAX_HOLD);

  localparam logic [2:0] ANODES_OFF   = 3'b111;
  localparam logic [7:0] CATHODES_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN0   = 2'd1,
    OWN1   = 2'd2,
    SWITCH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;      // 1: requester 1 was granted most recently
  logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [1:0]         digit_q, digit_d;
  logic               scan_wrap;
  logic               gnt0_q, gnt1_q;
  logic [2:0]         anodes_q, anodes_d;
  logic [7:0]         cathodes_q, cathodes_d;
  logic [11:0]        value;
  logic [3:0]         nibble;
  logic               own_d;

  function automatic state_t arbitrate(input logic r0, input logic r1, input logic last);
    state_t s;
    s = IDLE;
    if (r0 && r1)  s = last ? OWN0 : OWN1;
    else if (r0)   s = OWN0;
    else if (r1)   s = OWN1;
    return s;
  endfunction

  function automatic logic [7:0] hex7(input logic [3:0] h);
    logic [7:0] seg;
    seg = CATHODES_OFF;
    case (h)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = CATHODES_OFF;
    endcase
    return seg;
  endfunction

  // Free-running digit scan, independent of who owns the display.
  always_comb begin
    scan_wrap = (scan_q == SCAN_LAST);
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    digit_d   = digit_q;
    if (scan_wrap) digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
  end

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    hold_d   = hold_q;
    blank_d  = blank_q;
    hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;

    unique case (state_q)
      IDLE: state_d = arbitrate(req_bus.req0, req_bus.req1, last_q);
      OWN0: begin
        hold_d = hold_inc;
        if (!req_bus.req0)                           state_d = SWITCH;
        else if (req_bus.req1 && hold_inc == HOLD_MAX) state_d = SWITCH;
      end
      OWN1: begin
        hold_d = hold_inc;
        if (!req_bus.req1)                           state_d = SWITCH;
        else if (req_bus.req0 && hold_inc == HOLD_MAX) state_d = SWITCH;
      end
      SWITCH: begin
        blank_d = blank_q + 1'b1;
        if (blank_q == BLANK_LAST) state_d = arbitrate(req_bus.req0, req_bus.req1, last_q);
      end
      default: state_d = IDLE;
    endcase

    // Entry actions: OWN is only ever entered from IDLE or SWITCH.
    if (state_d == SWITCH && state_q != SWITCH) blank_d = '0;
    if ((state_d == OWN0 || state_d == OWN1) && state_d != state_q) begin
      hold_d = '0;
      last_d = (state_d == OWN1);
    end
  end

  // Outputs are registered from next-cycle values so that anodes, cathodes and
  // grants always describe the same state and scan slot.
  always_comb begin
    own_d  = (state_d == OWN0) || (state_d == OWN1);
    value  = (state_d == OWN1) ? req_bus.data1 : req_bus.data0;
    nibble = value[3:0];
    case (digit_d)
      2'd1:    nibble = value[7:4];
      2'd2:    nibble = value[11:8];
      default: nibble = value[3:0];
    endcase

    anodes_d = ANODES_OFF;
    if (own_d && scan_d >= GHOST_END) begin
      case (digit_d)
        2'd1:    anodes_d = 3'b101;
        2'd2:    anodes_d = 3'b011;
        default: anodes_d = 3'b110;
      endcase
    end
    // The cathode register doubles as the display latch: owner data reaches
    // the segments one cycle after it is presented.
    cathodes_d = (anodes_d == ANODES_OFF) ? CATHODES_OFF : hex7(nibble);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      hold_q     <= '0;
      blank_q    <= '0;
      scan_q     <= '0;
      digit_q    <= 2'd0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      anodes_q   <= ANODES_OFF;
      cathodes_q <= CATHODES_OFF;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      blank_q    <= blank_d;
      scan_q     <= scan_d;
      digit_q    <= digit_d;
      gnt0_q     <= (state_d == OWN0);
      gnt1_q     <= (state_d == OWN1);
      anodes_q   <= anodes_d;
      cathodes_q <= cathodes_d;
    end
  end

  assign req_bus.gnt0 = gnt0_q;
  assign req_bus.gnt1 = gnt1_q;
  assign anodes       = anodes_q;
  assign cathodes     = cathodes_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with short scan/blank/hold parameters.
// Outputs are sampled 1 time unit after each rising edge; e counts edges since reset release.
module tb_seg_display_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] anodes;
  logic [7:0] cathodes;
  int         checks = 0;
  int         failures = 0;
  int         e = 0;
  int         cnt;

  always #5 clk = ~clk;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(
    .SCAN_PERIOD (16),
    .GHOST_CYCLES(2),
    .BLANK_CYCLES(4),
    .MAX_HOLD    (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_bus (bus),
    .anodes  (anodes),
    .cathodes(cathodes)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic goto_edge(input int t);
    if (t > e) step(t - e);
  endtask

  task automatic apply_reset(input logic r0, input logic r1,
                             input logic [11:0] d0, input logic [11:0] d1);
    reset     = 1'b0;
    bus.req0  = r0;
    bus.req1  = r1;
    bus.data0 = d0;
    bus.data1 = d1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    e = 0;
  endtask

  task automatic check_disp(input string tag, input logic [2:0] an, input logic [7:0] ca);
    check({tag, "_an"}, 32'(anodes), 32'(an));
    check({tag, "_ca"}, 32'(cathodes), 32'(ca));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // 1: reset held with both requests high
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.data0 = 12'h3A7; bus.data1 = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt0", 32'(bus.gnt0), 0);
    check("rst_gnt1", 32'(bus.gnt1), 0);
    check_disp("rst", 3'b111, 8'hFF);
    bus.req1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    e = 0;
    step(1);
    check("rel_gnt0", 32'(bus.gnt0), 1);
    check("rel_gnt1", 32'(bus.gnt1), 0);

    // 2: scanning 12'h3A7 with ghost intervals
    check_disp("ghost_e1", 3'b111, 8'hFF);
    goto_edge(2);  check_disp("d0_e2",    3'b110, 8'hF8);
    goto_edge(15); check_disp("d0_e15",   3'b110, 8'hF8);
    goto_edge(16); check_disp("ghost_e16", 3'b111, 8'hFF);
    goto_edge(17); check_disp("ghost_e17", 3'b111, 8'hFF);
    goto_edge(18); check_disp("d1_e18",   3'b101, 8'h88);
    goto_edge(34); check_disp("d2_e34",   3'b011, 8'hB0);
    goto_edge(48); check_disp("ghost_e48", 3'b111, 8'hFF);
    goto_edge(50); check_disp("d0_e50",   3'b110, 8'hF8);

    // 3: tie-break, blank gap, round-robin, no direct handoff
    apply_reset(1'b0, 1'b0, 12'h123, 12'h456);
    step(2);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step(1);
    check("tie_gnt0", 32'(bus.gnt0), 1);
    check("tie_gnt1", 32'(bus.gnt1), 0);
    bus.req0 = 1'b0;
    step(1);
    check("blank1_gnt0", 32'(bus.gnt0), 0);
    check("blank1_gnt1", 32'(bus.gnt1), 0);
    check_disp("blank1", 3'b111, 8'hFF);
    step(3);
    check("blank4_gnt1", 32'(bus.gnt1), 0);
    step(1);
    check("handoff_gnt1", 32'(bus.gnt1), 1);
    bus.req1 = 1'b0;
    step(5);
    check("idle_gnt0", 32'(bus.gnt0), 0);
    check("idle_gnt1", 32'(bus.gnt1), 0);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step(1);
    check("rr_gnt0", 32'(bus.gnt0), 1);
    check("rr_gnt1", 32'(bus.gnt1), 0);
    bus.req1 = 1'b0;
    step(2);
    bus.req0 = 1'b0; bus.req1 = 1'b1;
    step(1);
    check("simul_gnt0", 32'(bus.gnt0), 0);
    check("simul_gnt1", 32'(bus.gnt1), 0);
    step(4);
    check("simul_late_gnt1", 32'(bus.gnt1), 1);

    // 4: bounded hold with a waiting requester, then unbounded hold alone
    apply_reset(1'b0, 1'b1, 12'h000, 12'h456);
    step(1);
    check("own1_gnt1", 32'(bus.gnt1), 1);
    bus.req0 = 1'b1;
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.gnt1) cnt++;
      else break;
    end
    check("hold_cycles", 32'(cnt), 32);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.gnt0) break;
      cnt++;
      step(1);
    end
    check("preempt_blank", 32'(cnt), 4);
    check("preempt_gnt0", 32'(bus.gnt0), 1);
    bus.req0 = 1'b0;
    step(5);
    check("back_gnt1", 32'(bus.gnt1), 1);
    cnt = 0;
    repeat (120) begin
      step(1);
      if (bus.gnt1) cnt++;
    end
    check("nopreempt_cycles", 32'(cnt), 120);
    bus.req0 = 1'b1;
    step(1);
    check("sat_preempt_gnt1", 32'(bus.gnt1), 0);
    step(4);
    check("sat_preempt_gnt0", 32'(bus.gnt0), 1);

    // 6: display lags data by one cycle
    apply_reset(1'b0, 1'b1, 12'h000, 12'h000);
    goto_edge(2);
    check_disp("lag_before", 3'b110, 8'hC0);
    bus.data1 = 12'hFFF;
    check("lag_same", 32'(cathodes), 32'hC0);
    step(1);
    check_disp("lag_after", 3'b110, 8'h8E);

    // 5: async reset mid-OWN0 and mid-SWITCH
    apply_reset(1'b1, 1'b0, 12'h3A7, 12'h000);
    goto_edge(18);
    check_disp("pre_areset", 3'b101, 8'h88);
    #2;
    reset = 1'b0;
    #1;
    check("areset_own_gnt0", 32'(bus.gnt0), 0);
    check_disp("areset_own", 3'b111, 8'hFF);
    @(negedge clk);
    reset = 1'b1;
    e = 0;
    goto_edge(2);
    check_disp("restart_d0", 3'b110, 8'hF8);
    bus.req0 = 1'b0;
    step(2);
    check("mid_switch_gnt0", 32'(bus.gnt0), 0);
    bus.req1 = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("areset_sw_gnt1", 32'(bus.gnt1), 0);
    check_disp("areset_sw", 3'b111, 8'hFF);
    @(negedge clk);
    reset = 1'b1;
    e = 0;
    step(1);
    check("after_sw_reset_gnt1", 32'(bus.gnt1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
